// File: rtl/present_key_schedule_if.sv
// Round-key streaming bundle between the PRESENT key schedule and its user.
// The master side supplies the key and start request and consumes the round keys.
interface present_key_schedule_if #(
  parameter int KEY_W = 80
);
  logic [KEY_W-1:0] key_i;
  logic             start_i;
  logic             dir_i;
  logic [63:0]      rk_o;
  logic [5:0]       rk_idx_o;
  logic             rk_valid_o;
  logic             rk_ready_i;
  logic             busy_o;
  logic             done_o;

  modport master (
    output key_i, start_i, dir_i, rk_ready_i,
    input  rk_o, rk_idx_o, rk_valid_o, busy_o, done_o
  );

  modport slave (
    input  key_i, start_i, dir_i, rk_ready_i,
    output rk_o, rk_idx_o, rk_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/present_key_schedule.sv
// Sequential PRESENT key schedule (80/128-bit keys) that streams ROUNDS+1 round keys
// in encryption order, or in decryption order after precomputing the final key.
module present_key_schedule #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input logic                   clk,
  input logic                   rst_n,
  present_key_schedule_if.slave ks
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_key_schedule: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_key_schedule: ROUNDS must be in 1..31");
  end

  // Low bit of the 5-bit round-counter field that is XORed into the key.
  localparam int              CLO      = (KEY_W == 128) ? 62 : 15;
  localparam logic [5:0]      LAST_IDX = 6'(ROUNDS + 1);
  localparam logic [4:0]      LAST_CNT = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, PRECOMP, EMIT} state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Forward update: rotate left 61, S-box the top nibble(s), mix in the counter.
  function automatic logic [KEY_W-1:0] f_upd(input logic [KEY_W-1:0] k, input logic [4:0] c);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sbox(r[KEY_W-5 -: 4]);
    r[CLO +: 5] = r[CLO +: 5] ^ c;
    return r;
  endfunction

  // Inverse update: undo the counter mix, inverse S-box, rotate right 61.
  function automatic logic [KEY_W-1:0] g_upd(input logic [KEY_W-1:0] k, input logic [4:0] c);
    logic [KEY_W-1:0] r;
    r = k;
    r[CLO +: 5] = r[CLO +: 5] ^ c;
    r[KEY_W-1 -: 4] = sbox_inv(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sbox_inv(r[KEY_W-5 -: 4]);
    return {r[60:0], r[KEY_W-1:61]};
  endfunction

  state_t           state, state_nxt;
  logic [KEY_W-1:0] key_reg, key_nxt;
  logic [5:0]       rk_idx, idx_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic             dir_q, dir_nxt;
  logic             done_q, done_nxt;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_reg <= '0;
      rk_idx  <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      key_reg <= key_nxt;
      rk_idx  <= idx_nxt;
      cnt     <= cnt_nxt;
      dir_q   <= dir_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_nxt = state;
    key_nxt   = key_reg;
    idx_nxt   = rk_idx;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ks.start_i) begin
          key_nxt = ks.key_i;
          dir_nxt = ks.dir_i;
          if (ks.dir_i) begin
            cnt_nxt   = 5'd1;
            state_nxt = PRECOMP;
          end else begin
            idx_nxt   = 6'd1;
            state_nxt = EMIT;
          end
        end
      end
      PRECOMP: begin
        // Walk forward to the last round key so it can be emitted first.
        key_nxt = f_upd(key_reg, cnt);
        cnt_nxt = cnt + 5'd1;
        if (cnt == LAST_CNT) begin
          idx_nxt   = LAST_IDX;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (ks.rk_ready_i) begin
          if (!dir_q) begin
            if (rk_idx == LAST_IDX) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              key_nxt = f_upd(key_reg, rk_idx[4:0]);
              idx_nxt = rk_idx + 6'd1;
            end
          end else begin
            if (rk_idx == 6'd1) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              key_nxt = g_upd(key_reg, 5'(rk_idx - 6'd1));
              idx_nxt = rk_idx - 6'd1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs come straight from registers: valid never depends on ready.
  assign ks.rk_o       = key_reg[KEY_W-1 -: 64];
  assign ks.rk_idx_o   = rk_idx;
  assign ks.rk_valid_o = (state == EMIT);
  assign ks.busy_o     = (state != IDLE);
  assign ks.done_o     = done_q;

endmodule
